// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the decode/execute boundary.
// Holds the datapath widths, the ALU control encodings and the packed
// control bundle latched by the issue stage alongside the operands.
package cpu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RADDR = 5;

  typedef enum logic [1:0] {
    FC_LOGIC       = 2'b00,
    FC_SHIFT_ARITH = 2'b01,
    FC_SLT         = 2'b10,
    FC_SLTU        = 2'b11
  } func_class_e;

  typedef enum logic [1:0] {
    SF_SLL  = 2'b00,
    SF_SRL  = 2'b01,
    SF_SRA  = 2'b10,
    SF_RSVD = 2'b11
  } shift_fn_e;

  typedef enum logic [1:0] {
    LF_AND   = 2'b00,
    LF_OR    = 2'b01,
    LF_XOR   = 2'b10,
    LF_PASSB = 2'b11
  } logic_fn_e;

  // Decoded control bundle held with the instruction.
  typedef struct packed {
    logic [1:0] shift_fn;
    logic [1:0] logic_fn;
    logic [1:0] func_class;
    logic       add_n_sub;
    logic       ext_word;
    logic       reg_write;
    logic       is_load;
    logic       use_imm;
    logic       use_pc;
  } ctrl_t;

  // Stores carry no dedicated flag: they use the immediate for the address
  // and neither write a register nor load.
  function automatic logic is_store(input ctrl_t c);
    return c.use_imm & ~c.reg_write & ~c.is_load;
  endfunction

endpackage

// File: rtl/operand_forward.sv
// operand_forward: per-operand bypass mux.
// Priority: MEM result (enabled, address match, data not pending) over
// WB write data (enabled, address match) over the stored operand.
// Register x0 never forwards and always returns the stored value.
// Ports:
//   rs_i                         source register address
//   stored_i                     operand latched in the stage
//   mem_en_i/mem_rd_i/mem_data_i MEM-stage result
//   mem_pending_i                MEM data not yet valid
//   wb_en_i/wb_rd_i/wb_data_i    register-file write port
//   data_o                       resolved operand
module operand_forward #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RADDR = 5
) (
  input  logic [RADDR-1:0] rs_i,
  input  logic [XLEN-1:0]  stored_i,
  input  logic             mem_en_i,
  input  logic [RADDR-1:0] mem_rd_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic             mem_pending_i,
  input  logic             wb_en_i,
  input  logic [RADDR-1:0] wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic [XLEN-1:0]  data_o
);

  always_comb begin
    data_o = stored_i;
    if (rs_i != '0) begin
      if (mem_en_i && !mem_pending_i && (mem_rd_i == rs_i))
        data_o = mem_data_i;
      else if (wb_en_i && (wb_rd_i == rs_i))
        data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/exec_issue_stage.sv
// exec_issue_stage: decode-to-execute pipeline register.
// Latches one decoded instruction under valid/ready, forwards operands from
// MEM/WB, snoops WB writes while holding, and bubbles on load-use hazards.
// Ports:
//   clk, reset_n (async, active low), flush (sync kill of held instruction)
//   dec_*        decoded instruction and handshake from decode
//   mem_fwd_*    MEM-stage forwarding source, mem_load_pending load hazard
//   wb_*         register-file write port (forward + snoop)
//   ex_ready/ex_valid handshake to the execution unit
//   A, B, StoreData, ShiftFn, LogicFn, FuncClass, AddnSub, ExtWord,
//   ex_reg_write, ex_is_load, ex_rd  execution-unit operands and controls
module exec_issue_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [XLEN-1:0]  dec_rs1_data,
  input  logic [XLEN-1:0]  dec_rs2_data,
  input  logic [RADDR-1:0] dec_rs1,
  input  logic [RADDR-1:0] dec_rs2,
  input  logic [RADDR-1:0] dec_rd,
  input  logic [XLEN-1:0]  dec_imm,
  input  logic [XLEN-1:0]  dec_pc,
  input  logic             dec_use_imm,
  input  logic             dec_use_pc,
  input  logic [1:0]       dec_ShiftFn,
  input  logic [1:0]       dec_LogicFn,
  input  logic [1:0]       dec_FuncClass,
  input  logic             dec_AddnSub,
  input  logic             dec_ExtWord,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic             mem_fwd_en,
  input  logic [RADDR-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             mem_load_pending,
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  A,
  output logic [XLEN-1:0]  B,
  output logic [XLEN-1:0]  StoreData,
  output logic [1:0]       ShiftFn,
  output logic [1:0]       LogicFn,
  output logic [1:0]       FuncClass,
  output logic             AddnSub,
  output logic             ExtWord,
  output logic             ex_reg_write,
  output logic             ex_is_load,
  output logic [RADDR-1:0] ex_rd
);

  import cpu_pkg::*;

  logic             held_q, held_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [RADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;

  logic             rs1_used, rs2_needed, hazard, capture;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

  operand_forward #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs1 (
    .rs_i          (rs1_q),
    .stored_i      (rs1_data_q),
    .mem_en_i      (mem_fwd_en),
    .mem_rd_i      (mem_fwd_rd),
    .mem_data_i    (mem_fwd_data),
    .mem_pending_i (mem_load_pending),
    .wb_en_i       (wb_en),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .data_o        (fwd_rs1)
  );

  operand_forward #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs2 (
    .rs_i          (rs2_q),
    .stored_i      (rs2_data_q),
    .mem_en_i      (mem_fwd_en),
    .mem_rd_i      (mem_fwd_rd),
    .mem_data_i    (mem_fwd_data),
    .mem_pending_i (mem_load_pending),
    .wb_en_i       (wb_en),
    .wb_rd_i       (wb_rd),
    .wb_data_i     (wb_data),
    .data_o        (fwd_rs2)
  );

  // StoreData is always forwarded, so a store depends on rs2 even though B
  // carries the immediate.
  always_comb begin
    rs1_used   = ~ctrl_q.use_pc;
    rs2_needed = ~ctrl_q.use_imm | is_store(ctrl_q);
    hazard     = mem_load_pending & (mem_fwd_rd != '0) &
                 ((rs1_used & (mem_fwd_rd == rs1_q)) |
                  (rs2_needed & (mem_fwd_rd == rs2_q)));
    ex_valid   = held_q & ~hazard;
    dec_ready  = ~held_q | (ex_valid & ex_ready);
    capture    = dec_valid & dec_ready;
  end

  always_comb begin
    held_d     = held_q;
    ctrl_d     = ctrl_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;

    if (capture) begin
      held_d     = 1'b1;
      ctrl_d     = '{shift_fn: dec_ShiftFn, logic_fn: dec_LogicFn,
                     func_class: dec_FuncClass, add_n_sub: dec_AddnSub,
                     ext_word: dec_ExtWord, reg_write: dec_reg_write,
                     is_load: dec_is_load, use_imm: dec_use_imm,
                     use_pc: dec_use_pc};
      rs1_d      = dec_rs1;
      rs2_d      = dec_rs2;
      rd_d       = dec_rd;
      imm_d      = dec_imm;
      pc_d       = dec_pc;
      // Register-file read-during-write: take the value being written.
      rs1_data_d = (wb_en && (dec_rs1 != '0) && (wb_rd == dec_rs1)) ? wb_data : dec_rs1_data;
      rs2_data_d = (wb_en && (dec_rs2 != '0) && (wb_rd == dec_rs2)) ? wb_data : dec_rs2_data;
    end else begin
      if (ex_valid && ex_ready)
        held_d = 1'b0;
      // Snoop WB so the operand survives the producer retiring.
      if (held_q && wb_en && (wb_rd != '0)) begin
        if (wb_rd == rs1_q) rs1_data_d = wb_data;
        if (wb_rd == rs2_q) rs2_data_d = wb_data;
      end
    end

    if (flush)
      held_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q     <= 1'b0;
      ctrl_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      held_q     <= held_d;
      ctrl_q     <= ctrl_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    A            = ctrl_q.use_pc  ? pc_q  : fwd_rs1;
    B            = ctrl_q.use_imm ? imm_q : fwd_rs2;
    StoreData    = fwd_rs2;
    ShiftFn      = ctrl_q.shift_fn;
    LogicFn      = ctrl_q.logic_fn;
    FuncClass    = ctrl_q.func_class;
    AddnSub      = ctrl_q.add_n_sub;
    ExtWord      = ctrl_q.ext_word;
    ex_reg_write = ctrl_q.reg_write;
    ex_is_load   = ctrl_q.is_load;
    ex_rd        = rd_q;
  end

endmodule

// File: tb/tb_exec_issue_stage.sv
// tb_exec_issue_stage: directed self-checking bench for exec_issue_stage.
module tb_exec_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_rs1_data, dec_rs2_data, dec_imm, dec_pc;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_imm, dec_use_pc;
  logic [1:0]  dec_ShiftFn, dec_LogicFn, dec_FuncClass;
  logic        dec_AddnSub, dec_ExtWord, dec_reg_write, dec_is_load;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_rd;
  logic [63:0] mem_fwd_data;
  logic        mem_load_pending;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [63:0] A, B, StoreData;
  logic [1:0]  ShiftFn, LogicFn, FuncClass;
  logic        AddnSub, ExtWord, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_issue_stage #(.XLEN(64), .RADDR(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_pc(dec_pc),
    .dec_use_imm(dec_use_imm), .dec_use_pc(dec_use_pc),
    .dec_ShiftFn(dec_ShiftFn), .dec_LogicFn(dec_LogicFn), .dec_FuncClass(dec_FuncClass),
    .dec_AddnSub(dec_AddnSub), .dec_ExtWord(dec_ExtWord),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .mem_load_pending(mem_load_pending),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .A(A), .B(B), .StoreData(StoreData),
    .ShiftFn(ShiftFn), .LogicFn(LogicFn), .FuncClass(FuncClass),
    .AddnSub(AddnSub), .ExtWord(ExtWord),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rd(ex_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    flush = 0; dec_valid = 0;
    dec_rs1_data = '0; dec_rs2_data = '0; dec_imm = '0; dec_pc = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_imm = 0; dec_use_pc = 0;
    dec_ShiftFn = '0; dec_LogicFn = '0; dec_FuncClass = '0;
    dec_AddnSub = 0; dec_ExtWord = 0; dec_reg_write = 1; dec_is_load = 0;
    mem_fwd_en = 0; mem_fwd_rd = '0; mem_fwd_data = '0; mem_load_pending = 0;
    wb_en = 0; wb_rd = '0; wb_data = '0;
    ex_ready = 1;
  endtask

  task automatic present(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2);
    dec_valid = 1; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
    dec_rs1_data = d1; dec_rs2_data = d2;
  endtask

  initial begin
    defaults();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_StoreData", StoreData, 0);
    chk("rst_FuncClass", FuncClass, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    reset_n = 1;
    #1;
    chk("rst_dec_ready", dec_ready, 1);

    // Basic pass
    present(5'd1, 5'd2, 5'd3, 64'd5, 64'd7);
    dec_FuncClass = 2'b01; dec_AddnSub = 0;
    tick();
    dec_valid = 0;
    #1;
    chk("basic_ex_valid", ex_valid, 1);
    chk("basic_A", A, 5);
    chk("basic_B", B, 7);
    chk("basic_FuncClass", FuncClass, 2'b01);
    chk("basic_ex_rd", ex_rd, 3);
    chk("basic_dec_ready", dec_ready, 1);
    tick();
    chk("drain_ex_valid", ex_valid, 0);

    // MEM forward onto rs1, then x0
    dec_FuncClass = 0;
    present(5'd3, 5'd4, 5'd5, 64'h11, 64'h22);
    ex_ready = 0;
    tick();
    dec_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'hDEAD;
    #1;
    chk("memfwd_A", A, 64'hDEAD);
    chk("memfwd_B", B, 64'h22);
    chk("memfwd_dec_ready_bp", dec_ready, 0);
    present(5'd0, 5'd4, 5'd5, 64'h0, 64'h22);
    ex_ready = 1;
    tick();
    dec_valid = 0; ex_ready = 0;
    mem_fwd_rd = 5'd0; mem_fwd_data = 64'hBEEF;
    #1;
    chk("memfwd_x0_A", A, 0);
    mem_fwd_rd = 5'd4;
    #1;
    chk("memfwd_rs2_B", B, 64'hBEEF);
    mem_fwd_en = 0;

    // Load-use on rs2
    ex_ready = 1;
    present(5'd5, 5'd4, 5'd6, 64'h10, 64'h20);
    tick();
    dec_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 5'd4; mem_load_pending = 1; mem_fwd_data = 64'h55;
    #1;
    chk("lu_ex_valid", ex_valid, 0);
    chk("lu_dec_ready", dec_ready, 0);
    tick();
    chk("lu_hold_ex_valid", ex_valid, 0);
    mem_load_pending = 0; mem_fwd_data = 64'h99;
    #1;
    chk("lu_rel_ex_valid", ex_valid, 1);
    chk("lu_rel_B", B, 64'h99);
    chk("lu_rel_A", A, 64'h10);
    mem_load_pending = 1; mem_fwd_rd = 5'd0;
    #1;
    chk("lu_x0_no_hazard", ex_valid, 1);
    mem_load_pending = 0; mem_fwd_en = 0;
    tick();

    // Immediate B: pending load to rs2 is not a hazard for an ALU-imm op
    present(5'd1, 5'd4, 5'd7, 64'h1, 64'h33);
    dec_use_imm = 1; dec_imm = 64'h40; ex_ready = 0;
    tick();
    dec_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 5'd4; mem_load_pending = 1;
    #1;
    chk("imm_no_hazard", ex_valid, 1);
    chk("imm_B", B, 64'h40);
    // Store: rs2 feeds StoreData, so the same pending load stalls it
    ex_ready = 1;
    present(5'd1, 5'd4, 5'd0, 64'h1, 64'h33);
    dec_use_imm = 1; dec_imm = 64'h8; dec_reg_write = 0; dec_is_load = 0;
    tick();
    dec_valid = 0; ex_ready = 0;
    #1;
    chk("store_hazard", ex_valid, 0);
    mem_load_pending = 0; mem_fwd_en = 0;
    #1;
    chk("store_ex_valid", ex_valid, 1);
    chk("store_StoreData", StoreData, 64'h33);
    chk("store_B", B, 64'h8);
    dec_use_imm = 0; dec_reg_write = 1; dec_imm = '0;

    // WB snoop while backpressured
    ex_ready = 1;
    present(5'd6, 5'd2, 5'd8, 64'h1, 64'h2);
    tick();
    dec_valid = 0; ex_ready = 0;
    wb_en = 1; wb_rd = 5'd6; wb_data = 64'h1234;
    #1;
    chk("snoop_c1_A", A, 64'h1234);
    mem_fwd_en = 1; mem_fwd_rd = 5'd6; mem_fwd_data = 64'hAAAA;
    #1;
    chk("mem_over_wb_A", A, 64'hAAAA);
    mem_fwd_en = 0;
    tick();
    wb_en = 0;
    #1;
    chk("snoop_c2_A", A, 64'h1234);
    tick();
    chk("snoop_c3_A", A, 64'h1234);
    chk("snoop_c3_ex_valid", ex_valid, 1);

    // Capture-time WB bypass
    ex_ready = 1;
    present(5'd9, 5'd9, 5'd9, 64'h5, 64'h6);
    wb_en = 1; wb_rd = 5'd9; wb_data = 64'h777;
    tick();
    wb_en = 0; dec_valid = 0; ex_ready = 0;
    #1;
    chk("cap_byp_A", A, 64'h777);
    chk("cap_byp_B", B, 64'h777);

    // Flush overrides a same-cycle capture
    ex_ready = 1; flush = 1;
    present(5'd1, 5'd2, 5'd10, 64'h3, 64'h4);
    #1;
    chk("flush_dec_ready", dec_ready, 1);
    tick();
    flush = 0; dec_valid = 0;
    chk("flush_ex_valid", ex_valid, 0);

    // Async reset while stalled
    present(5'd7, 5'd8, 5'd11, 64'hA, 64'hB);
    tick();
    dec_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 5'd7; mem_load_pending = 1;
    #1;
    chk("rst_stall_pre_A", A, 64'hA);
    reset_n = 0;
    #1;
    chk("rst_stall_ex_valid", ex_valid, 0);
    chk("rst_stall_A", A, 0);
    chk("rst_stall_B", B, 0);
    mem_fwd_en = 0; mem_load_pending = 0;
    #1;
    reset_n = 1;

    // Throughput: 10 back-to-back instructions
    ex_ready = 1;
    for (int i = 0; i < 10; i++) begin
      present(5'd1, 5'd2, 5'(i + 1), 64'(i * 3), 64'(i + 100));
      tick();
      chk("tp_ex_valid", ex_valid, 1);
      chk("tp_ex_rd", ex_rd, 64'(i + 1));
      chk("tp_A", A, 64'(i * 3));
    end
    dec_valid = 0;
    tick();
    chk("tp_end_ex_valid", ex_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
